// File: rtl/regfile_wb_sched_if.sv
// Writeback scheduler bundle: issue/hazard, two producer request channels, register file write port.
// Pure wiring, no latency; producers are backpressured by withholding a_ack/m_ack.
// slave = scheduler side, master = issue stage / producers / register file side.
interface regfile_wb_sched_if #(
    parameter int AW   = 4,
    parameter int DW   = 16,
    parameter int NREG = 16
);
    logic            issue_vld;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   rs_q;
    logic [AW-1:0]   rt_q;
    logic            hazard;
    logic            a_req;
    logic [AW-1:0]   a_rd;
    logic [DW-1:0]   a_data;
    logic            a_ack;
    logic            m_req;
    logic [AW-1:0]   m_rd;
    logic [DW-1:0]   m_data;
    logic            m_ack;
    logic            wr;
    logic [AW-1:0]   Rd;
    logic [DW-1:0]   RW;
    logic [NREG-1:0] busy;
    logic            issue_err;

    modport slave (
        input  issue_vld, issue_rd, rs_q, rt_q,
        input  a_req, a_rd, a_data, m_req, m_rd, m_data,
        output hazard, a_ack, m_ack, wr, Rd, RW, busy, issue_err
    );

    modport master (
        output issue_vld, issue_rd, rs_q, rt_q,
        output a_req, a_rd, a_data, m_req, m_rd, m_data,
        input  hazard, a_ack, m_ack, wr, Rd, RW, busy, issue_err
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates ALU/memory writes onto one register file port, tracks pending writes for hazards.
// Latency: ack combinational with request, wr/Rd/RW registered one cycle after the ack edge.
// Backpressure: a losing producer holds its request until acked; WBS_FIXED_PRI_EN selects M-over-A fixed priority.
module regfile_wb_sched #(
    parameter int AW   = 4,
    parameter int DW   = 16,
    parameter int NREG = 16
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_sched_if.slave   bus
);
    logic            r_wr;
    logic [AW-1:0]   r_rd;
    logic [DW-1:0]   r_rw;
    logic [NREG-1:0] r_busy;
    logic            r_issue_err;

    logic            w_hazard;
    logic            w_gnt_a;
    logic            w_gnt_m;
    logic            w_gnt;
    logic            w_set;
    logic [AW-1:0]   w_wr_rd;
    logic [DW-1:0]   w_wr_data;
    logic [NREG-1:0] w_busy_nxt;

    // No bypass: a register being written this cycle still stalls readers.
    assign w_hazard = r_busy[bus.rs_q] | r_busy[bus.rt_q]
                    | (bus.issue_vld & r_busy[bus.issue_rd]);

`ifdef WBS_FIXED_PRI_EN
    assign w_gnt_m = bus.m_req;
    assign w_gnt_a = bus.a_req & ~bus.m_req;
`else
    logic r_last_gnt_m;

    assign w_gnt_a = bus.a_req & (~bus.m_req | r_last_gnt_m);
    assign w_gnt_m = bus.m_req & ~w_gnt_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_gnt_m <= 1'b1;
        end else if (w_gnt) begin
            r_last_gnt_m <= w_gnt_m;
        end
    end
`endif

    assign w_gnt     = w_gnt_a | w_gnt_m;
    assign w_wr_rd   = w_gnt_m ? bus.m_rd   : bus.a_rd;
    assign w_wr_data = w_gnt_m ? bus.m_data : bus.a_data;
    assign w_set     = bus.issue_vld & ~w_hazard;

    // Set applied after clear so a fresh issue keeps ownership of the register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_gnt) begin
            w_busy_nxt[w_wr_rd] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr        <= 1'b0;
            r_rd        <= '0;
            r_rw        <= '0;
            r_busy      <= '0;
            r_issue_err <= 1'b0;
        end else begin
            r_wr <= w_gnt;
            if (w_gnt) begin
                r_rd <= w_wr_rd;
                r_rw <= w_wr_data;
            end
            r_busy      <= w_busy_nxt;
            r_issue_err <= r_issue_err | (bus.issue_vld & w_hazard);
        end
    end

    assign bus.hazard    = w_hazard;
    assign bus.a_ack     = w_gnt_a;
    assign bus.m_ack     = w_gnt_m;
    assign bus.wr        = r_wr;
    assign bus.Rd        = r_rd;
    assign bus.RW        = r_rw;
    assign bus.busy      = r_busy;
    assign bus.issue_err = r_issue_err;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected register-file writes are queued by the stimulus
// and retired by an independent monitor; control/status outputs are checked inline.
module tb_regfile_wb_sched;
    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NREG = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wexp_t;

    wexp_t exp_q[$];

    regfile_wb_sched_if #(.AW(AW), .DW(DW), .NREG(NREG)) bus ();

    regfile_wb_sched #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        wexp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && bus.wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got Rd=%0h RW=%0h expected none", bus.Rd, bus.RW);
            end else begin
                wexp_t e;
                e = exp_q.pop_front();
                chk("wr_Rd", 32'(bus.Rd), 32'(e.rd));
                chk("wr_RW", 32'(bus.RW), 32'(e.data));
            end
        end
    end

    initial begin
        logic exp_a [4];
        bus.issue_vld = 1'b0; bus.issue_rd = '0; bus.rs_q = '0; bus.rt_q = '0;
        bus.a_req = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.m_req = 1'b0; bus.m_rd = '0; bus.m_data = '0;

        #3;
        chk("rst_wr",   32'(bus.wr), 32'd0);
        chk("rst_Rd",   32'(bus.Rd), 32'd0);
        chk("rst_RW",   32'(bus.RW), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err",  32'(bus.issue_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nxt();

        // Contention right after reset: A first, then alternate.
        bus.a_req = 1'b1; bus.a_rd = 4'd1; bus.a_data = 16'h1111;
        bus.m_req = 1'b1; bus.m_rd = 4'd2; bus.m_data = 16'h2222;
`ifdef WBS_FIXED_PRI_EN
        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            if (exp_a[i]) push(4'd1, 16'h1111);
            else          push(4'd2, 16'h2222);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_a_ack", 32'(bus.a_ack), 32'(exp_a[i]));
            chk("cont_m_ack", 32'(bus.m_ack), 32'(!exp_a[i]));
            nxt();
        end
        bus.a_req = 1'b0; bus.m_req = 1'b0;
        nxt();

        // Single uncontended ALU write.
        bus.a_req = 1'b1; bus.a_rd = 4'd3; bus.a_data = 16'hA5A5;
        push(4'd3, 16'hA5A5);
        @(negedge clk);
        chk("single_a_ack", 32'(bus.a_ack), 32'd1);
        chk("single_m_ack", 32'(bus.m_ack), 32'd0);
        nxt();
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("single_wr_hi", 32'(bus.wr), 32'd1);
        nxt();
        @(negedge clk);
        chk("single_wr_lo", 32'(bus.wr), 32'd0);
        nxt();

        // Scoreboard set, RAW hazard, clear by M grant.
        bus.issue_vld = 1'b1; bus.issue_rd = 4'd5;
        @(negedge clk);
        chk("sb_issue_haz", 32'(bus.hazard), 32'd0);
        nxt();
        bus.issue_vld = 1'b0; bus.rs_q = 4'd5;
        @(negedge clk);
        chk("sb_busy_set", 32'(bus.busy), 32'h0020);
        chk("sb_raw_haz",  32'(bus.hazard), 32'd1);
        nxt();
        bus.m_req = 1'b1; bus.m_rd = 4'd5; bus.m_data = 16'h5555;
        push(4'd5, 16'h5555);
        @(negedge clk);
        chk("sb_m_ack",     32'(bus.m_ack), 32'd1);
        chk("sb_haz_grant", 32'(bus.hazard), 32'd1);
        nxt();
        bus.m_req = 1'b0;
        @(negedge clk);
        chk("sb_busy_clr", 32'(bus.busy), 32'h0000);
        chk("sb_haz_clr",  32'(bus.hazard), 32'd0);
        bus.rs_q = 4'd0;
        nxt();

        // Same edge: WAW issue is rejected while the grant clears the bit.
        bus.issue_vld = 1'b1; bus.issue_rd = 4'd7;
        nxt();
        bus.issue_vld = 1'b1; bus.issue_rd = 4'd7;
        bus.a_req = 1'b1; bus.a_rd = 4'd7; bus.a_data = 16'h7777;
        push(4'd7, 16'h7777);
        @(negedge clk);
        chk("waw_haz",   32'(bus.hazard), 32'd1);
        chk("waw_a_ack", 32'(bus.a_ack), 32'd1);
        nxt();
        bus.issue_vld = 1'b0; bus.a_req = 1'b0;
        @(negedge clk);
        chk("waw_err",  32'(bus.issue_err), 32'd1);
        chk("waw_busy", 32'(bus.busy), 32'h0000);
        nxt();
        // Same edge with bit clear beforehand: set wins.
        bus.issue_vld = 1'b1; bus.issue_rd = 4'd7;
        bus.a_req = 1'b1; bus.a_rd = 4'd7; bus.a_data = 16'h7070;
        push(4'd7, 16'h7070);
        @(negedge clk);
        chk("setwin_haz", 32'(bus.hazard), 32'd0);
        nxt();
        bus.issue_vld = 1'b0; bus.a_req = 1'b0;
        @(negedge clk);
        chk("setwin_busy", 32'(bus.busy), 32'h0080);
        chk("err_sticky",  32'(bus.issue_err), 32'd1);
        nxt();

        // Fill the scoreboard, start writes, then reset mid-stream.
        for (int i = 0; i < NREG; i++) begin
            bus.issue_vld = 1'b1; bus.issue_rd = AW'(i);
            bus.rs_q = AW'(i); bus.rt_q = AW'(i);
            nxt();
        end
        bus.issue_vld = 1'b0; bus.rs_q = '0; bus.rt_q = '0;
        @(negedge clk);
        chk("fill_busy", 32'(bus.busy), 32'hFFFF);
        nxt();
        bus.a_req = 1'b1; bus.a_rd = 4'd0; bus.a_data = 16'hBEEF;
        push(4'd0, 16'hBEEF);
        @(negedge clk);
        chk("b2b_a_ack", 32'(bus.a_ack), 32'd1);
        nxt();
        bus.a_rd = 4'd1; bus.a_data = 16'hC0DE;
        @(negedge clk);
        #2;
        rst = 1'b0;
        bus.a_req = 1'b0;
        #1;
        chk("mid_rst_wr",   32'(bus.wr), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_err",  32'(bus.issue_err), 32'd0);
        chk("mid_rst_Rd",   32'(bus.Rd), 32'd0);
        #1;
        rst = 1'b1;
        nxt();

        // Last pre-reset grant was A; reset must restore A-first.
        bus.a_req = 1'b1; bus.a_rd = 4'd4; bus.a_data = 16'h4444;
        bus.m_req = 1'b1; bus.m_rd = 4'd8; bus.m_data = 16'h8888;
`ifdef WBS_FIXED_PRI_EN
        push(4'd8, 16'h8888);
        push(4'd8, 16'h8888);
`else
        push(4'd4, 16'h4444);
        push(4'd8, 16'h8888);
`endif
        @(negedge clk);
`ifdef WBS_FIXED_PRI_EN
        chk("post_rst_m_ack0", 32'(bus.m_ack), 32'd1);
`else
        chk("post_rst_a_ack0", 32'(bus.a_ack), 32'd1);
`endif
        nxt();
        @(negedge clk);
        chk("post_rst_m_ack1", 32'(bus.m_ack), 32'd1);
        nxt();
        bus.a_req = 1'b0; bus.m_req = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_wr",      32'(bus.wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
